// File: rtl/fpnew_share_arbiter.sv
// Round-robin front end that time-shares one FPNew instance among NUM_REQ requesters.
// Requests go into a one-entry issue register; results are routed back using the FPU tag.
module fpnew_share_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int WIDTH           = 32,
  parameter int TAG_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*3*WIDTH-1:0]   req_operands_i,
  input  logic [NUM_REQ*4-1:0]         req_op_i,
  input  logic [NUM_REQ-1:0]           req_op_mod_i,
  input  logic [NUM_REQ*3-1:0]         req_rnd_i,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [WIDTH-1:0]             rsp_result_o,
  output logic [4:0]                   rsp_status_o,
  output logic [3*WIDTH-1:0]           fpu_operands_o,
  output logic [3:0]                   fpu_op_o,
  output logic                         fpu_op_mod_o,
  output logic [2:0]                   fpu_rnd_mode_o,
  output logic [TAG_WIDTH-1:0]         fpu_tag_o,
  output logic                         fpu_in_valid_o,
  input  logic                         fpu_in_ready_i,
  input  logic [WIDTH-1:0]             fpu_result_i,
  input  logic [4:0]                   fpu_status_i,
  input  logic [TAG_WIDTH-1:0]         fpu_tag_i,
  input  logic                         fpu_out_valid_i,
  output logic                         fpu_out_ready_o,
  output logic                         fpu_flush_o,
  output logic                         busy_o
);

  localparam int CNT_W = 4;

  // Outstanding-op counter step; a response against an empty counter holds it at zero.
  function automatic logic [CNT_W-1:0] cnt_update(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    if (inc && !dec)      return cnt + CNT_W'(1);
    else if (dec && !inc) return (cnt == '0) ? '0 : cnt - CNT_W'(1);
    else                  return cnt;
  endfunction

  logic [TAG_WIDTH-1:0] rr_ptr;
  logic [CNT_W-1:0]     cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   acc_vec;
  logic [NUM_REQ-1:0]   rsp_hs;
  logic                 grant_vld;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic [TAG_WIDTH:0]   scan;
  logic                 may_load;
  logic                 accept;

  logic                 vld_p1;
  logic [3*WIDTH-1:0]   ops_p1;
  logic [3:0]           op_p1;
  logic                 op_mod_p1;
  logic [2:0]           rnd_p1;
  logic [TAG_WIDTH-1:0] tag_p1;

  // Stage 0: eligibility and round-robin grant starting at rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid_i[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (TAG_WIDTH+1)'(k);
      if (scan >= (TAG_WIDTH+1)'(NUM_REQ)) scan = scan - (TAG_WIDTH+1)'(NUM_REQ);
      if (!grant_vld && elig[scan[TAG_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan[TAG_WIDTH-1:0];
      end
    end
  end

  assign may_load = !vld_p1 || fpu_in_ready_i;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (grant_vld && may_load && !flush_i) req_ready_o[grant_idx] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid_o[i] = !flush_i && fpu_out_valid_i && (fpu_tag_i == TAG_WIDTH'(i));
  end

  assign acc_vec         = req_ready_o & req_valid_i;
  assign accept          = |acc_vec;
  assign rsp_hs          = rsp_valid_o & rsp_ready_i;
  assign fpu_out_ready_o = flush_i || rsp_ready_i[fpu_tag_i];
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;
  assign fpu_flush_o     = flush_i;

  // Stage 1: issue register feeding the FPU input port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1    <= 1'b0;
      ops_p1    <= '0;
      op_p1     <= '0;
      op_mod_p1 <= 1'b0;
      rnd_p1    <= '0;
      tag_p1    <= '0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      ops_p1    <= req_operands_i[grant_idx*3*WIDTH +: 3*WIDTH];
      op_p1     <= req_op_i[grant_idx*4 +: 4];
      op_mod_p1 <= req_op_mod_i[grant_idx];
      rnd_p1    <= req_rnd_i[grant_idx*3 +: 3];
      tag_p1    <= grant_idx;
    end else if (fpu_in_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == TAG_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + TAG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_i || flush_i) cnt[i] <= '0;
      else                  cnt[i] <= cnt_update(cnt[i], acc_vec[i], rsp_hs[i]);
    end
  end

  always_comb begin
    busy_o = vld_p1;
    for (int i = 0; i < NUM_REQ; i++)
      if (cnt[i] != '0) busy_o = 1'b1;
  end

  assign fpu_in_valid_o = vld_p1;
  assign fpu_operands_o = ops_p1;
  assign fpu_op_o       = op_p1;
  assign fpu_op_mod_o   = op_mod_p1;
  assign fpu_rnd_mode_o = rnd_p1;
  assign fpu_tag_o      = tag_p1;

endmodule

// File: tb/tb_fpnew_share_arbiter.sv
// Directed testbench for fpnew_share_arbiter: grant order, caps, backpressure, stalls, flush, reset.
module tb_fpnew_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int TAG_W   = 2;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic                       flush_i;
  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ*3*WIDTH-1:0] req_operands_i;
  logic [NUM_REQ*4-1:0]       req_op_i;
  logic [NUM_REQ-1:0]         req_op_mod_i;
  logic [NUM_REQ*3-1:0]       req_rnd_i;
  logic [NUM_REQ-1:0]         rsp_valid_o;
  logic [NUM_REQ-1:0]         rsp_ready_i;
  logic [WIDTH-1:0]           rsp_result_o;
  logic [4:0]                 rsp_status_o;
  logic [3*WIDTH-1:0]         fpu_operands_o;
  logic [3:0]                 fpu_op_o;
  logic                       fpu_op_mod_o;
  logic [2:0]                 fpu_rnd_mode_o;
  logic [TAG_W-1:0]           fpu_tag_o;
  logic                       fpu_in_valid_o;
  logic                       fpu_in_ready_i;
  logic [WIDTH-1:0]           fpu_result_i;
  logic [4:0]                 fpu_status_i;
  logic [TAG_W-1:0]           fpu_tag_i;
  logic                       fpu_out_valid_i;
  logic                       fpu_out_ready_o;
  logic                       fpu_flush_o;
  logic                       busy_o;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk_i = ~clk_i;

  fpnew_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TAG_WIDTH(TAG_W), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_operands_i(req_operands_i),
    .req_op_i(req_op_i), .req_op_mod_i(req_op_mod_i), .req_rnd_i(req_rnd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_status_o(rsp_status_o), .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
    .fpu_op_mod_o(fpu_op_mod_o), .fpu_rnd_mode_o(fpu_rnd_mode_o), .fpu_tag_o(fpu_tag_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i), .fpu_result_i(fpu_result_i),
    .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i), .fpu_out_valid_i(fpu_out_valid_i),
    .fpu_out_ready_o(fpu_out_ready_o), .fpu_flush_o(fpu_flush_o), .busy_o(busy_o)
  );

  // Operand k of requester r is 0x1000_0000*(k+1) + r; op = r+1, op_mod = r[0], rnd = r.
  function automatic logic [3*WIDTH-1:0] exp_ops(input int r);
    logic [3*WIDTH-1:0] v;
    for (int k = 0; k < 3; k++) v[k*WIDTH +: WIDTH] = 32'h1000_0000 * (k + 1) + r;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = '0; rsp_ready_i = '0;
    fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; fpu_tag_i = '0;
    fpu_result_i = '0; fpu_status_i = '0;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (fpu_in_valid_o !== 1'b0) begin fails++; $display("FAIL reset_in_valid got %b want 0", fpu_in_valid_o); end
    tests_run++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready_o); end
    tests_run++; if (rsp_valid_o !== 4'b0000) begin fails++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid_o); end
    tests_run++; if (fpu_out_ready_o !== 1'b0) begin fails++; $display("FAIL reset_out_ready got %b want 0", fpu_out_ready_o); end
    tests_run++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy_o); end
    tests_run++; if (fpu_operands_o !== '0 || fpu_tag_o !== '0 || fpu_op_o !== '0)
      begin fails++; $display("FAIL reset_data got ops=%h tag=%0d op=%0d want zeros", fpu_operands_o, fpu_tag_o, fpu_op_o); end
    tests_run++; if (fpu_flush_o !== 1'b0) begin fails++; $display("FAIL reset_flush got %b want 0", fpu_flush_o); end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready_i = 4'hF; fpu_in_ready_i = 1'b1; req_valid_i = 4'b0010;
    #1;
    tests_run++; if (req_ready_o !== 4'b0010) begin fails++; $display("FAIL single_ready got %b want 0010", req_ready_o); end
    tick();
    req_valid_i = '0;
    tests_run++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== 2'd1)
      begin fails++; $display("FAIL single_issue got vld=%b tag=%0d want 1/1", fpu_in_valid_o, fpu_tag_o); end
    tests_run++; if (fpu_operands_o !== exp_ops(1) || fpu_op_o !== 4'd2 || fpu_op_mod_o !== 1'b1 || fpu_rnd_mode_o !== 3'd1)
      begin fails++; $display("FAIL single_fields got ops=%h op=%0d mod=%b rnd=%0d", fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o); end
    tick();
    tests_run++; if (fpu_in_valid_o !== 1'b0 || busy_o !== 1'b1)
      begin fails++; $display("FAIL single_drain got vld=%b busy=%b want 0/1", fpu_in_valid_o, busy_o); end
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; fpu_result_i = 32'h3F80_0000; fpu_status_i = 5'h01;
    #1;
    tests_run++; if (rsp_valid_o !== 4'b0010 || fpu_out_ready_o !== 1'b1)
      begin fails++; $display("FAIL single_rsp got valid=%b ordy=%b want 0010/1", rsp_valid_o, fpu_out_ready_o); end
    tests_run++; if (rsp_result_o !== 32'h3F80_0000 || rsp_status_o !== 5'h01)
      begin fails++; $display("FAIL single_rsp_data got %h/%h want 3f800000/01", rsp_result_o, rsp_status_o); end
    tick();
    fpu_out_valid_i = 1'b0;
    #1;
    tests_run++; if (busy_o !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b want 0", busy_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_tag;
    do_reset();
    rsp_ready_i = 4'hF; fpu_in_ready_i = 1'b1; req_valid_i = 4'hF;
    #1;
    tests_run++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL rr_first_ready got %b want 0001", req_ready_o); end
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_tag = 2'(k % 4);
      tests_run++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== exp_tag)
        begin fails++; $display("FAIL rr_tag_%0d got vld=%b tag=%0d want 1/%0d", k, fpu_in_valid_o, fpu_tag_o, exp_tag); end
      if (k == 2) begin
        tests_run++; if (fpu_op_o !== 4'd3 || fpu_operands_o !== exp_ops(2))
          begin fails++; $display("FAIL rr_fields2 got op=%0d ops=%h want 3/%h", fpu_op_o, fpu_operands_o, exp_ops(2)); end
      end
    end
    req_valid_i = '0;
  endtask

  task automatic test_cap();
    int acc;
    do_reset();
    rsp_ready_i = 4'hF; fpu_in_ready_i = 1'b1; req_valid_i = 4'b0100;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (req_ready_o[2]) acc++;
      tick();
    end
    tests_run++; if (acc !== 4) begin fails++; $display("FAIL cap_accepts got %0d want 4", acc); end
    tests_run++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL cap_ready got %b want 0000", req_ready_o); end
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd2;
    tick();
    fpu_out_valid_i = 1'b0;
    #1;
    tests_run++; if (req_ready_o !== 4'b0100) begin fails++; $display("FAIL cap_reopen got %b want 0100", req_ready_o); end
    tick();
    tests_run++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL cap_refull got %b want 0000", req_ready_o); end
    req_valid_i = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready_i = 4'hF; fpu_in_ready_i = 1'b1; req_valid_i = 4'b0011;
    tick();
    fpu_in_ready_i = 1'b0;
    #1;
    tests_run++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL bp_ready got %b want 0000", req_ready_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== 2'd0 || fpu_operands_o !== exp_ops(0) || req_ready_o !== 4'b0000)
        begin fails++; $display("FAIL bp_hold_%0d got vld=%b tag=%0d ops=%h rdy=%b", k, fpu_in_valid_o, fpu_tag_o, fpu_operands_o, req_ready_o); end
    end
    fpu_in_ready_i = 1'b1;
    #1;
    tests_run++; if (req_ready_o !== 4'b0010) begin fails++; $display("FAIL bp_release_ready got %b want 0010", req_ready_o); end
    tick();
    req_valid_i = '0;
    tests_run++; if (fpu_in_valid_o !== 1'b1 || fpu_tag_o !== 2'd1)
      begin fails++; $display("FAIL bp_next_issue got vld=%b tag=%0d want 1/1", fpu_in_valid_o, fpu_tag_o); end
  endtask

  task automatic test_rsp_stall();
    do_reset();
    rsp_ready_i = 4'hF; fpu_in_ready_i = 1'b1; req_valid_i = 4'b1000;
    tick();
    req_valid_i = '0;
    tick();
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd3; rsp_ready_i = 4'b0111;
    #1;
    tests_run++; if (fpu_out_ready_o !== 1'b0 || rsp_valid_o !== 4'b1000)
      begin fails++; $display("FAIL stall_out got ordy=%b valid=%b want 0/1000", fpu_out_ready_o, rsp_valid_o); end
    tick(); tick();
    tests_run++; if (busy_o !== 1'b1) begin fails++; $display("FAIL stall_busy got %b want 1", busy_o); end
    rsp_ready_i = 4'hF;
    #1;
    tests_run++; if (fpu_out_ready_o !== 1'b1) begin fails++; $display("FAIL stall_release got %b want 1", fpu_out_ready_o); end
    tick();
    fpu_out_valid_i = 1'b0;
    #1;
    tests_run++; if (busy_o !== 1'b0) begin fails++; $display("FAIL stall_done_busy got %b want 0", busy_o); end
  endtask

  task automatic test_flush();
    do_reset();
    rsp_ready_i = 4'hF; fpu_in_ready_i = 1'b1; req_valid_i = 4'b0111;
    tick(); tick(); tick();
    req_valid_i = 4'hF; fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; flush_i = 1'b1;
    #1;
    tests_run++; if (fpu_flush_o !== 1'b1 || req_ready_o !== 4'b0000 || rsp_valid_o !== 4'b0000 || fpu_out_ready_o !== 1'b1)
      begin fails++; $display("FAIL flush_cycle got fl=%b rdy=%b rv=%b ordy=%b want 1/0000/0000/1", fpu_flush_o, req_ready_o, rsp_valid_o, fpu_out_ready_o); end
    tick();
    flush_i = 1'b0; req_valid_i = '0; fpu_out_valid_i = 1'b0;
    #1;
    tests_run++; if (fpu_flush_o !== 1'b0 || busy_o !== 1'b0 || fpu_in_valid_o !== 1'b0)
      begin fails++; $display("FAIL flush_after got fl=%b busy=%b vld=%b want 0/0/0", fpu_flush_o, busy_o, fpu_in_valid_o); end
    req_valid_i = 4'hF;
    #1;
    tests_run++; if (req_ready_o !== 4'b1000) begin fails++; $display("FAIL flush_rr_kept got %b want 1000", req_ready_o); end
    req_valid_i = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rsp_ready_i = 4'hF; fpu_in_ready_i = 1'b1; req_valid_i = 4'hF;
    tick(); tick();
    rst_i = 1'b1; req_valid_i = '0; rsp_ready_i = '0;
    tick();
    rst_i = 1'b0;
    #1;
    tests_run++; if (fpu_in_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 4'b0000)
      begin fails++; $display("FAIL midrst_ctrl got vld=%b busy=%b rdy=%b want 0/0/0000", fpu_in_valid_o, busy_o, req_ready_o); end
    tests_run++; if (fpu_operands_o !== '0 || fpu_tag_o !== '0 || fpu_op_o !== '0 || fpu_rnd_mode_o !== '0)
      begin fails++; $display("FAIL midrst_data got ops=%h tag=%0d op=%0d rnd=%0d want zeros", fpu_operands_o, fpu_tag_o, fpu_op_o, fpu_rnd_mode_o); end
  endtask

  initial begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req_operands_i[r*3*WIDTH +: 3*WIDTH] = exp_ops(r);
      req_op_i[r*4 +: 4]                   = 4'(r + 1);
      req_op_mod_i[r]                      = 1'(r % 2);
      req_rnd_i[r*3 +: 3]                  = 3'(r);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_cap();
    test_backpressure();
    test_rsp_stall();
    test_flush();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
